// File: rtl/io_out_buf.sv
// rtl/io_out_buf.sv - core output stage: per-port holding registers plus {addr,data} FWFT FIFO
//
// Every core output write (out_en/addr_out/data_out) updates the addressed
// holding register and is queued for an external consumer. The core never
// stalls, so a write into a full FIFO without a concurrent pop is dropped and
// recorded in the sticky ovf flag.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   out_en, addr_out, data_out    core output write
//   port_data, port_stb           last value per port / one-cycle update pulse
//   m_valid, m_addr, m_data       FIFO head, held until popped
//   m_ready                       consumer accepts head
//   count, full, empty            FIFO occupancy and status
//   ovf, ovf_clr                  sticky overflow flag and its clear

module io_out_buf #(
    parameter int NUBITS = 32,
    parameter int NUIOOU = 8,
    parameter int FDEPTH = 8,
    parameter int AW     = (NUIOOU > 1) ? $clog2(NUIOOU) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     out_en,
    input  logic [AW-1:0]            addr_out,
    input  logic [NUBITS-1:0]        data_out,
    output logic [NUIOOU*NUBITS-1:0] port_data,
    output logic [NUIOOU-1:0]        port_stb,
    output logic                     m_valid,
    output logic [AW-1:0]            m_addr,
    output logic [NUBITS-1:0]        m_data,
    input  logic                     m_ready,
    output logic [$clog2(FDEPTH):0]  count,
    output logic                     full,
    output logic                     empty,
    output logic                     ovf,
    input  logic                     ovf_clr
);

    localparam int PW = $clog2(FDEPTH);
    localparam int CW = PW + 1;
    localparam int EW = AW + NUBITS;

    // Port bank write decode. With a single port the address is ignored;
    // otherwise out-of-range addresses skip the bank but still get queued.
    logic [AW-1:0]     bank_addr;
    logic [NUIOOU-1:0] wr_sel;

    always_comb begin
        bank_addr = (NUIOOU == 1) ? '0 : addr_out;
        wr_sel    = '0;
        for (int k = 0; k < NUIOOU; k++) begin
            wr_sel[k] = out_en && (bank_addr == AW'(k));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            port_data <= '0;
            port_stb  <= '0;
        end else begin
            port_stb <= wr_sel;
            for (int k = 0; k < NUIOOU; k++) begin
                if (wr_sel[k]) begin
                    port_data[k*NUBITS +: NUBITS] <= data_out;
                end
            end
        end
    end

    // Circular FIFO. Pointers are PW bits and wrap naturally since FDEPTH is
    // a power of two; the separate count disambiguates full from empty.
    logic [EW-1:0] mem [FDEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic          push;
    logic          pop;

    assign full    = (cnt == CW'(FDEPTH));
    assign empty   = (cnt == '0);
    assign m_valid = ~empty;
    assign count   = cnt;

    assign pop  = m_valid & m_ready;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign push = out_en & (~full | pop);

    assign {m_addr, m_data} = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[wr_ptr] <= {addr_out, data_out};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Sticky overflow; a new drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (out_en && full && !pop) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_io_out_buf.sv
// tb/tb_io_out_buf.sv - scoreboard testbench for io_out_buf

module tb_io_out_buf;

    logic         clk = 1'b0;
    logic         rst;
    logic         out_en;
    logic [2:0]   addr_out;
    logic [31:0]  data_out;
    logic [255:0] port_data;
    logic [7:0]   port_stb;
    logic         m_valid;
    logic [2:0]   m_addr;
    logic [31:0]  m_data;
    logic         m_ready;
    logic [3:0]   count;
    logic         full;
    logic         empty;
    logic         ovf;
    logic         ovf_clr;

    int checks = 0;
    int errors = 0;

    logic [34:0] sb [$];

    io_out_buf #(.NUBITS(32), .NUIOOU(8), .FDEPTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .out_en    (out_en),
        .addr_out  (addr_out),
        .data_out  (data_out),
        .port_data (port_data),
        .port_stb  (port_stb),
        .m_valid   (m_valid),
        .m_addr    (m_addr),
        .m_data    (m_data),
        .m_ready   (m_ready),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Apply inputs for one edge, return 1 time unit after it.
    task automatic cyc(input logic oe, input logic [2:0] a, input logic [31:0] d,
                       input logic rdy, input logic clr);
        out_en   = oe;
        addr_out = a;
        data_out = d;
        m_ready  = rdy;
        ovf_clr  = clr;
        @(posedge clk);
        #1;
    endtask

    // Core write; exp_push states whether the FIFO is expected to take it.
    task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic rdy,
                      input logic exp_push);
        if (exp_push) sb.push_back({a, d});
        cyc(1'b1, a, d, rdy, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        out_en = 1'b0; addr_out = '0; data_out = '0; m_ready = 1'b0; ovf_clr = 1'b0;

        // Monitor: a pop happens at the next edge whenever valid&ready is seen here.
        fork
            forever begin
                @(negedge clk);
                if (!rst && m_valid && m_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_pop got=%0h/%0h exp=none", m_addr, m_data);
                    end else begin
                        chk("head", {29'd0, m_addr, m_data}, {29'd0, sb.pop_front()});
                    end
                end
            end
        join_none

        // Reset then idle
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("rst_port_data", {63'd0, port_data != '0}, 64'd0);
        chk("rst_port_stb", port_stb, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_ovf", ovf, 0);
        rst = 1'b0;
        cyc(0, 0, 0, 0, 0);

        // Single write
        wr(3'd3, 32'h0000_00A5, 0, 1);
        chk("single_stb", port_stb, 8'h08);
        chk("single_port3", port_data[3*32 +: 32], 32'hA5);
        chk("single_valid", m_valid, 1);
        chk("single_addr", m_addr, 3);
        chk("single_data", m_data, 32'hA5);
        chk("single_count", count, 1);
        cyc(0, 0, 0, 1, 0);
        chk("single_stb_drop", port_stb, 0);
        chk("single_drained", count, 0);

        // Fill and overflow
        for (int i = 1; i <= 8; i++) wr(3'd0, 32'(i), 0, 1);
        chk("fill_count", count, 8);
        chk("fill_full", full, 1);
        chk("fill_ovf_clean", ovf, 0);
        wr(3'd0, 32'd9, 0, 0);
        chk("ovf_set", ovf, 1);
        chk("ovf_count", count, 8);
        chk("ovf_port0", port_data[31:0], 9);
        chk("ovf_stb", port_stb, 8'h01);
        cyc(0, 0, 0, 0, 1);
        chk("ovf_cleared", ovf, 0);

        // Full with simultaneous pop
        wr(3'd1, 32'd10, 1, 1);
        chk("fullpop_ovf", ovf, 0);
        chk("fullpop_count", count, 8);
        chk("fullpop_head", m_data, 2);
        chk("fullpop_port1", port_data[1*32 +: 32], 10);
        for (int i = 0; i < 8; i++) cyc(0, 0, 0, 1, 0);
        chk("fullpop_empty", empty, 1);

        // Wrap-around streaming
        for (int i = 0; i < 40; i++) begin
            wr(3'(i % 8), 32'h100 + 32'(i), 1, 1);
            chk("stream_count_le1", {63'd0, count <= 4'd1}, 1);
        end
        chk("stream_port7", port_data[7*32 +: 32], 32'h100 + 32'd39);
        cyc(0, 0, 0, 1, 0);
        chk("stream_empty", empty, 1);

        // ovf_clr race
        for (int i = 0; i < 8; i++) wr(3'd5, 32'h200 + 32'(i), 0, 1);
        out_en = 1'b1; addr_out = 3'd5; data_out = 32'h2FF; m_ready = 1'b0; ovf_clr = 1'b1;
        @(posedge clk);
        #1;
        chk("race_ovf_set_wins", ovf, 1);
        cyc(0, 0, 0, 0, 1);
        chk("race_ovf_cleared", ovf, 0);

        // Mid-operation reset at count 5, with a write in the reset cycle
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0);
        chk("pre_rst_count", count, 5);
        rst = 1'b1;
        cyc(1, 3'd2, 32'hDEAD, 0, 0);
        rst = 1'b0;
        sb.delete();
        chk("midrst_count", count, 0);
        chk("midrst_valid", m_valid, 0);
        chk("midrst_empty", empty, 1);
        chk("midrst_stb", port_stb, 0);
        chk("midrst_port2", port_data[2*32 +: 32], 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);
        chk("post_rst_valid", m_valid, 0);

        chk("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
